hazard_stall_ctrl: RTL

Parametrised pipeline hazard controller for the 5-stage MIPS core, sitting between the ID stage and the pipeline-register write enables. It detects load-use hazards against the ID/EX load and stalls for a configurable number of cycles, LOAD_LAT, to match slower data memories. It also flushes on taken branches and freezes the whole pipe while data memory is busy. It supersedes the single-cycle combinational load-use detector.

---
 rtl/hazard_pkg.sv | 23 ++
 rtl/hazard_stall_ctrl_if.sv | 50 +++++
 rtl/hazard_sat_cnt.sv | 31 +++
 rtl/hazard_stall_ctrl.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and constants for the pipeline hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

   // Controller state: free-running or inside a multi-cycle load-use stall.
   typedef enum logic [0:0] {
      RUN      = 1'b0,
      LU_STALL = 1'b1
   } hz_state_t;

   // Architectural zero register; a load targeting it never creates a hazard.
   localparam int unsigned REG_ZERO = 0;

   // Legal range of load-use stall cycles.
   localparam int LOAD_LAT_MIN = 1;
   localparam int LOAD_LAT_MAX = 7;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_stall_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_ctrl_if
// Description : Pipeline-side signal bundle of the hazard controller. The
//               master side is the pipeline (hazard sources, enable sinks),
//               the slave side is the controller itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_stall_ctrl_if #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
);
   // Hazard sources from the pipeline
   logic              id_ex_memread;
   logic [REG_AW-1:0] id_ex_rt;
   logic [REG_AW-1:0] if_id_rs;
   logic [REG_AW-1:0] if_id_rt;
   logic              if_id_uses_rt;
   logic              branch_taken;
   logic              dmem_busy;

   // Pipeline-register enables and status
   logic              pc_write;
   logic              if_id_write;
   logic              control_muxsig;
   logic              if_id_flush;
   logic              pipe_freeze;
   logic              stall_active;

   // Performance counters
   logic [CNT_W-1:0]  lu_stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;
   logic [CNT_W-1:0]  freeze_cnt;

   modport master (
      output id_ex_memread, id_ex_rt, if_id_rs, if_id_rt, if_id_uses_rt,
             branch_taken, dmem_busy,
      input  pc_write, if_id_write, control_muxsig, if_id_flush, pipe_freeze,
             stall_active, lu_stall_cnt, flush_cnt, freeze_cnt
   );

   modport slave (
      input  id_ex_memread, id_ex_rt, if_id_rs, if_id_rt, if_id_uses_rt,
             branch_taken, dmem_busy,
      output pc_write, if_id_write, control_muxsig, if_id_flush, pipe_freeze,
             stall_active, lu_stall_cnt, flush_cnt, freeze_cnt
   );

endinterface : hazard_stall_ctrl_if
`default_nettype wire

// File: rtl/hazard_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module      : hazard_sat_cnt
// Description : Saturating event counter; sticks at all-ones, cleared only by
//               the asynchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_sat_cnt #(
   parameter int CNT_W = 16
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic             inc,
   output logic      [CNT_W-1:0] count
);

   logic [CNT_W-1:0] r_count;

   // Count qualifying cycles, holding at the maximum value once reached.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (inc && (r_count != {CNT_W{1'b1}})) begin
         r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign count = r_count;

endmodule : hazard_sat_cnt
`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_ctrl
// Description : Pipeline hazard controller. Detects load-use hazards against
//               the load in ID/EX and inserts LOAD_LAT bubbles, flushes IF/ID
//               on taken branches and freezes the back end while data memory
//               is busy. Optional performance counters are built when the
//               macro HAZARD_PERF_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_AW   = 5,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 16
) (
   input wire logic           clk,
   input wire logic           rst_n,
   hazard_stall_ctrl_if.slave hz_bus
);

   localparam int              REM_W      = $clog2(LOAD_LAT + 1);
   localparam logic [REM_W-1:0] c_rem_one  = REM_W'(1);
   localparam logic [REM_W-1:0] c_rem_init = REM_W'(LOAD_LAT - 1);
   localparam logic [REG_AW-1:0] c_reg_zero = REG_AW'(REG_ZERO);

   if ((LOAD_LAT < LOAD_LAT_MIN) || (LOAD_LAT > LOAD_LAT_MAX)) begin : g_load_lat_range_err
      $error("hazard_stall_ctrl: LOAD_LAT out of range 1..7");
   end

   hz_state_t        r_state;
   hz_state_t        w_state_nxt;
   logic [REM_W-1:0] r_rem;
   logic [REM_W-1:0] w_rem_nxt;

   logic w_lu_hit;
   logic w_pc_write;
   logic w_if_id_write;
   logic w_control_muxsig;
   logic w_if_id_flush;
   logic w_pipe_freeze;

   // Load-use hit; r0 is never a real dependency and rt only counts when read.
   assign w_lu_hit = hz_bus.id_ex_memread
                   & (hz_bus.id_ex_rt != c_reg_zero)
                   & ((hz_bus.id_ex_rt == hz_bus.if_id_rs)
                      | (hz_bus.if_id_uses_rt & (hz_bus.id_ex_rt == hz_bus.if_id_rt)));

   // State and remaining-stall register; reset abandons any stall in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= RUN;
         r_rem   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_rem   <= w_rem_nxt;
      end
   end

   // Prioritised output and next-state decode: busy, branch, hazard, normal.
   always_comb begin
      w_state_nxt      = r_state;
      w_rem_nxt        = r_rem;
      w_pc_write       = 1'b1;
      w_if_id_write    = 1'b1;
      w_control_muxsig = 1'b0;
      w_if_id_flush    = 1'b0;
      w_pipe_freeze    = 1'b0;

      if (!rst_n) begin
         // Hold the front end and inject bubbles while reset is asserted.
         w_pc_write       = 1'b0;
         w_if_id_write    = 1'b0;
         w_control_muxsig = 1'b1;
      end else if (hz_bus.dmem_busy) begin
         // Everything waits; branch and hazard are re-judged after release.
         w_pipe_freeze    = 1'b1;
         w_pc_write       = 1'b0;
         w_if_id_write    = 1'b0;
      end else if (hz_bus.branch_taken) begin
         // Wrong-path instruction in IF/ID: squash it and drop any stall.
         w_control_muxsig = 1'b1;
         w_if_id_flush    = 1'b1;
         w_state_nxt      = RUN;
         w_rem_nxt        = '0;
      end else if (r_state == LU_STALL) begin
         w_pc_write       = 1'b0;
         w_if_id_write    = 1'b0;
         w_control_muxsig = 1'b1;
         w_rem_nxt        = r_rem - c_rem_one;
         if (r_rem == c_rem_one) begin
            w_state_nxt = RUN;
         end
      end else if (w_lu_hit) begin
         // First bubble comes from RUN; further ones are counted down in rem.
         w_pc_write       = 1'b0;
         w_if_id_write    = 1'b0;
         w_control_muxsig = 1'b1;
         if (LOAD_LAT > 1) begin
            w_state_nxt = LU_STALL;
            w_rem_nxt   = c_rem_init;
         end
      end
   end

   assign hz_bus.pc_write       = w_pc_write;
   assign hz_bus.if_id_write    = w_if_id_write;
   assign hz_bus.control_muxsig = w_control_muxsig;
   assign hz_bus.if_id_flush    = w_if_id_flush;
   assign hz_bus.pipe_freeze    = w_pipe_freeze;
   assign hz_bus.stall_active   = (r_state == LU_STALL);

`ifdef HAZARD_PERF_CNT_EN
   logic w_lu_inc;

   assign w_lu_inc = w_control_muxsig & ~w_if_id_flush;

   hazard_sat_cnt #(.CNT_W(CNT_W)) u_lu_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_lu_inc),
      .count (hz_bus.lu_stall_cnt)
   );

   hazard_sat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_if_id_flush),
      .count (hz_bus.flush_cnt)
   );

   hazard_sat_cnt #(.CNT_W(CNT_W)) u_freeze_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_pipe_freeze),
      .count (hz_bus.freeze_cnt)
   );
`else
   assign hz_bus.lu_stall_cnt = {CNT_W{1'b0}};
   assign hz_bus.flush_cnt    = {CNT_W{1'b0}};
   assign hz_bus.freeze_cnt   = {CNT_W{1'b0}};
`endif

endmodule : hazard_stall_ctrl
`default_nettype wire
